sw_systolic_scorer: RTL



---
 rtl/sw_systolic_scorer_pkg.sv | 25 ++
 rtl/sw_systolic_scorer_pe.sv | 99 +++++++++
 rtl/sw_systolic_scorer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sw_systolic_scorer_pkg.sv
// Shared types and default parameters for the Smith-Waterman score engine.
package design_variables;

  typedef logic [1:0] letter_t;

  localparam letter_t LETTER_A = 2'b00;
  localparam letter_t LETTER_G = 2'b01;
  localparam letter_t LETTER_T = 2'b10;
  localparam letter_t LETTER_C = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DONE
  } state_t;

  localparam int DEF_SEQ_LEN          = 32;
  localparam int DEF_LETTERS_PER_BEAT = 4;
  localparam int DEF_SCORE_WIDTH      = 8;
  localparam int DEF_MATCH_SCORE      = 2;
  localparam int DEF_MISMATCH_PENALTY = 1;
  localparam int DEF_GAP_PENALTY      = 1;

endpackage

// File: rtl/sw_systolic_scorer_pe.sv
// One systolic processing element: holds query letter i and scores one cell per edge.
// SW_SCORE_POSITION_EN adds a database-index counter and best-position register.
module sw_pe
  import design_variables::*;
#(
  parameter int SCORE_WIDTH      = DEF_SCORE_WIDTH,
  parameter int MATCH_SCORE      = DEF_MATCH_SCORE,
  parameter int MISMATCH_PENALTY = DEF_MISMATCH_PENALTY,
  parameter int GAP_PENALTY      = DEF_GAP_PENALTY
`ifdef SW_SCORE_POSITION_EN
  , parameter int POS_W          = 5
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   load_en,
  input  letter_t                load_letter,
  input  letter_t                db_in,
  input  logic                   db_valid_in,
  input  logic [SCORE_WIDTH-1:0] h_up,
  output letter_t                db_out,
  output logic                   db_valid_out,
  output logic [SCORE_WIDTH-1:0] h_out,
  output logic [SCORE_WIDTH-1:0] max_out
`ifdef SW_SCORE_POSITION_EN
  , output logic [POS_W-1:0]     pos_out
`endif
);

  // Two guard bits keep Hdiag + MATCH_SCORE from overflowing before saturation.
  localparam int CW = SCORE_WIDTH + 2;
  localparam logic signed [CW-1:0] H_MAX = CW'((1 << SCORE_WIDTH) - 1);

  letter_t                 q_reg;
  logic [SCORE_WIDTH-1:0]  diag_q;
  logic signed [CW-1:0]    sub, t_diag, t_up, t_left, cand;
  logic [SCORE_WIDTH-1:0]  h_next;
`ifdef SW_SCORE_POSITION_EN
  logic [POS_W-1:0]        db_idx;
`endif

  always_comb begin
    sub    = (q_reg == db_in) ? CW'(MATCH_SCORE) : -CW'(MISMATCH_PENALTY);
    t_diag = $signed({2'b00, diag_q}) + sub;
    t_up   = $signed({2'b00, h_up}) - CW'(GAP_PENALTY);
    t_left = $signed({2'b00, h_out}) - CW'(GAP_PENALTY);
    cand   = '0;
    if (t_diag > cand) cand = t_diag;
    if (t_up > cand)   cand = t_up;
    if (t_left > cand) cand = t_left;
    h_next = (cand > H_MAX) ? H_MAX[SCORE_WIDTH-1:0] : cand[SCORE_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg        <= LETTER_A;
      diag_q       <= '0;
      h_out        <= '0;
      max_out      <= '0;
      db_out       <= LETTER_A;
      db_valid_out <= 1'b0;
`ifdef SW_SCORE_POSITION_EN
      db_idx       <= '0;
      pos_out      <= '0;
`endif
    end else begin
      if (load_en) q_reg <= load_letter;
      if (clr) begin
        diag_q       <= '0;
        h_out        <= '0;
        max_out      <= '0;
        db_out       <= LETTER_A;
        db_valid_out <= 1'b0;
`ifdef SW_SCORE_POSITION_EN
        db_idx       <= '0;
        pos_out      <= '0;
`endif
      end else if (en) begin
        db_out       <= db_in;
        db_valid_out <= db_valid_in;
        diag_q       <= h_up;
        // Flush slots carry no letter; a zero H keeps them out of later cells.
        h_out        <= db_valid_in ? h_next : '0;
        if (db_valid_in && (h_next > max_out)) begin
          max_out <= h_next;
`ifdef SW_SCORE_POSITION_EN
          pos_out <= db_idx;
`endif
        end
`ifdef SW_SCORE_POSITION_EN
        if (db_valid_in) db_idx <= db_idx + 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/sw_systolic_scorer.sv
// Smith-Waterman local-alignment score engine: load, systolic compute, max-reduce.
// SW_SCORE_POSITION_EN adds query_end/db_end outputs locating the best cell.
module sw_systolic_scorer
  import design_variables::*;
#(
  parameter int SEQ_LEN          = DEF_SEQ_LEN,
  parameter int LETTERS_PER_BEAT = DEF_LETTERS_PER_BEAT,
  parameter int SCORE_WIDTH      = DEF_SCORE_WIDTH,
  parameter int MATCH_SCORE      = DEF_MATCH_SCORE,
  parameter int MISMATCH_PENALTY = DEF_MISMATCH_PENALTY,
  parameter int GAP_PENALTY      = DEF_GAP_PENALTY
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            ready,
  input  logic [2*LETTERS_PER_BEAT-1:0]   query_seq_in,
  input  logic [2*LETTERS_PER_BEAT-1:0]   database_seq_in,
  output logic [SCORE_WIDTH-1:0]          score,
  output logic                            output_valid
`ifdef SW_SCORE_POSITION_EN
  , output logic [$clog2(SEQ_LEN)-1:0]    query_end
  , output logic [$clog2(SEQ_LEN)-1:0]    db_end
`endif
);

  localparam int IW    = 2 * LETTERS_PER_BEAT;
  localparam int BEATS = SEQ_LEN / LETTERS_PER_BEAT;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CCW   = $clog2(2 * SEQ_LEN);
  localparam int DBW   = 2 * SEQ_LEN;
  localparam int POS_W = $clog2(SEQ_LEN);

  state_t                 state, state_next;
  logic [BW-1:0]          beat_cnt;
  logic [CCW-1:0]         comp_cnt;
  logic [DBW-1:0]         db_buf;
  logic [DBW+IW-1:0]      db_cat;
  logic                   load_phase, compute_phase;

  logic [SCORE_WIDTH-1:0] pe_h   [SEQ_LEN];
  logic [SCORE_WIDTH-1:0] pe_max [SEQ_LEN];
  logic [SCORE_WIDTH-1:0] up_h   [SEQ_LEN];
  letter_t                pe_db  [SEQ_LEN];
  letter_t                in_db  [SEQ_LEN];
  logic                   pe_dbv [SEQ_LEN];
  logic                   in_dbv [SEQ_LEN];
  logic [SCORE_WIDTH-1:0] best_max;
`ifdef SW_SCORE_POSITION_EN
  logic [POS_W-1:0]       pe_pos [SEQ_LEN];
  logic [POS_W-1:0]       best_q, best_d;
`endif

  assign load_phase    = (state == ST_LOAD);
  assign compute_phase = (state == ST_COMPUTE);
  assign db_cat        = {database_seq_in, db_buf};

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (start) state_next = ST_LOAD;
      ST_LOAD:    if (beat_cnt == BW'(BEATS - 1)) state_next = ST_COMPUTE;
      ST_COMPUTE: if (comp_cnt == CCW'(2 * SEQ_LEN - 1)) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ready        <= 1'b1;
      output_valid <= 1'b0;
      score        <= '0;
      beat_cnt     <= '0;
      comp_cnt     <= '0;
      db_buf       <= '0;
`ifdef SW_SCORE_POSITION_EN
      query_end    <= '0;
      db_end       <= '0;
`endif
    end else begin
      state        <= state_next;
      ready        <= (state_next == ST_IDLE);
      output_valid <= (state_next == ST_DONE);
      case (state)
        ST_IDLE: beat_cnt <= '0;
        ST_LOAD: begin
          beat_cnt <= beat_cnt + 1'b1;
          db_buf   <= db_cat[DBW+IW-1:IW];
          comp_cnt <= '0;
        end
        ST_COMPUTE: begin
          comp_cnt <= comp_cnt + 1'b1;
          db_buf   <= {2'b00, db_buf[DBW-1:2]};
          // The final compute edge only flushes, so the PE maxima are already settled.
          if (state_next == ST_DONE) begin
            score <= best_max;
`ifdef SW_SCORE_POSITION_EN
            query_end <= best_q;
            db_end    <= best_d;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < SEQ_LEN; i++) begin : g_pe
    if (i == 0) begin : g_head
      assign up_h[i]   = '0;
      assign in_db[i]  = db_buf[1:0];
      assign in_dbv[i] = (comp_cnt < CCW'(SEQ_LEN));
    end else begin : g_link
      assign up_h[i]   = pe_h[i-1];
      assign in_db[i]  = pe_db[i-1];
      assign in_dbv[i] = pe_dbv[i-1];
    end

    sw_pe #(
      .SCORE_WIDTH      (SCORE_WIDTH),
      .MATCH_SCORE      (MATCH_SCORE),
      .MISMATCH_PENALTY (MISMATCH_PENALTY),
      .GAP_PENALTY      (GAP_PENALTY)
`ifdef SW_SCORE_POSITION_EN
      , .POS_W          (POS_W)
`endif
    ) u_pe (
      .clk          (clk),
      .rst          (rst),
      .clr          (load_phase),
      .en           (compute_phase),
      .load_en      (load_phase && (beat_cnt == BW'(i / LETTERS_PER_BEAT))),
      .load_letter  (query_seq_in[2*(i%LETTERS_PER_BEAT) +: 2]),
      .db_in        (in_db[i]),
      .db_valid_in  (in_dbv[i]),
      .h_up         (up_h[i]),
      .db_out       (pe_db[i]),
      .db_valid_out (pe_dbv[i]),
      .h_out        (pe_h[i]),
      .max_out      (pe_max[i])
`ifdef SW_SCORE_POSITION_EN
      , .pos_out    (pe_pos[i])
`endif
    );
  end

  // Strictly-greater scan so the lowest query index wins ties.
  always_comb begin
    best_max = pe_max[0];
`ifdef SW_SCORE_POSITION_EN
    best_q = '0;
    best_d = pe_pos[0];
`endif
    for (int unsigned i = 1; i < SEQ_LEN; i++) begin
      if (pe_max[i] > best_max) begin
        best_max = pe_max[i];
`ifdef SW_SCORE_POSITION_EN
        best_q = POS_W'(i);
        best_d = pe_pos[i];
`endif
      end
    end
  end

endmodule
